dino_sprite_draw: RTL and testbench
===================================

// Module: dino_sprite_draw
// PURPOSE
//  Downstream consumer of the dino jump logic: watches dinoY/dinoMovement and repaints the dino sprite.
//  Sends a pixel stream to the LCD pixel-write arbiter: erase the old rectangle (BG), then paint the new one (FG).
//  Signals drawDoneDino back to the jump logic, which clears dinoMovement.
//  Sits between the dino jump logic and the LCD pixel-write arbiter.
// PARAMETERS
//  DINO_X      9'd20    screen column of sprite left edge
//  DINO_W      8'd16    sprite width, pixels (>=1)
//  DINO_H      8'd20    sprite height, pixels (>=1)
//  SCREEN_BASE 8'd220   screen row = SCREEN_BASE - dinoY gives the sprite top row
//  INIT_Y      8'd101   dinoY value treated as already drawn after reset (floor)
//  FG_COLOR    16'hFFFF RGB565 sprite colour
//  BG_COLOR    16'h0000 RGB565 background colour
// PORTS
//  clk           in   1   system clock
//  rst           in   1   synchronous, active-high reset
//  dinoY         in   8   dino height from jump logic (floor = 101, larger = higher)
//  dinoMovement  in   1   level: sprite position is stale and needs a repaint
//  redraw        in   1   one-cycle pulse: force repaint at the current dinoY even if it is unchanged
//  pix_ready     in   1   arbiter accepts pixel this cycle
//  pix_valid     out  1   pixel beat valid
//  pix_x         out  9   pixel column
//  pix_y         out  8   pixel row
//  pix_color     out  16  RGB565 colour
//  drawDoneDino  out  1   one-cycle pulse: repaint finished
//  busy          out  1   high in any state other than IDLE
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge): state=IDLE; pix_valid=0, pix_x=0, pix_y=0, pix_color=0; drawDoneDino=0; busy=0.
//   Also lastY=INIT_Y, row=col=0.
//  Reset mid-pass: the pass is abandoned with no drawDoneDino. The first cycle after reset is IDLE.
//  FSM states: IDLE, ERASE, DRAW, DONE.
//  IDLE, trigger = dinoMovement | redraw:
//   - On trigger, latch newY=dinoY and oldY=lastY; row=col=0.
//   - Next state is ERASE if oldY!=newY, else DRAW.
//  ERASE: stream the old rectangle in BG_COLOR.
//  DRAW: stream the new rectangle in FG_COLOR.
//  Pixel address for both passes: pix_x = DINO_X + col; pix_y = SCREEN_BASE - Y + row.
//   - Y is oldY in ERASE and newY in DRAW.
//   - All arithmetic is modulo the port width (8/9 bit); no clipping.
//  Raster order: col fastest (0..DINO_W-1), then row (0..DINO_H-1).
//  Handshake:
//   - pix_valid=1 throughout ERASE/DRAW.
//   - pix_x, pix_y and pix_color are held stable until pix_valid&pix_ready.
//   - The counters advance only on that handshake; no beat is dropped or duplicated.
//  On the accepted last beat (row=H-1, col=W-1): ERASE -> DRAW with row=col=0; DRAW -> DONE.
//  DONE (exactly 1 cycle): drawDoneDino=1, pix_valid=0, lastY<=newY, then -> IDLE.
//  Latency with pix_ready held 1, trigger sampled at cycle t:
//   - Erase+draw: first beat at t+1; drawDoneDino at t+2*W*H+1.
//   - Draw only: drawDoneDino at t+W*H+1.
//  dinoY/dinoMovement/redraw changes while busy are ignored (values are latched).
//   - The jump logic re-asserts dinoMovement if Y moved, so a new pass starts from IDLE.
//  Back-to-back passes: dinoMovement is cleared by the jump logic in the cycle after DONE.
//   - If it is still 1 in IDLE, a new pass starts; no idle gap is required.
//  pix_ready=0 for any number of cycles stalls the pass indefinitely; outputs are held.
// TESTING
//  Case 1, reset then quiet:
//   - Stimulus: rst 2 cycles, dinoMovement=0, redraw=0 for 50 cycles.
//   - Response: pix_valid=0, busy=0, drawDoneDino=0 throughout.
//  Case 2, jump step:
//   - Stimulus: dinoY=112, dinoMovement=1 at t, pix_ready=1.
//   - Response: 320 BG beats at rows 119..138, cols 20..35 (oldY=101).
//   - Then 320 FG beats at rows 108..127.
//   - drawDoneDino single pulse at t+641.
//  Case 3, forced redraw:
//   - Stimulus: redraw pulse with dinoY=101 after reset.
//   - Response: no BG beats; 320 FG beats; drawDoneDino at t+321.
//  Case 4, backpressure:
//   - Stimulus: pix_ready toggles 1,0,0,1 on a repeating pattern.
//   - Response: exactly 640 accepted beats in raster order.
//   - Outputs stable during every stall; one drawDoneDino.
//  Case 5, Y change mid-pass:
//   - Stimulus: dinoY goes 112->121 during DRAW; dinoMovement is re-asserted.
//   - Response: first pass completes at 112.
//   - Second pass erases 112 and draws 121.
//  Case 6, reset mid-pass:
//   - Stimulus: rst during beat 200 of ERASE.
//   - Response: next cycle pix_valid=0, busy=0, no drawDoneDino.
//   - A following trigger erases from INIT_Y.

Source files
------------

// File: rtl/dino_sprite_draw.sv
// Repaints the dino sprite: erases the previously drawn rectangle in BG, then
// streams the new rectangle in FG over a valid/ready pixel port.
module dino_sprite_draw #(
    parameter logic [8:0]  DINO_X      = 9'd20,
    parameter logic [7:0]  DINO_W      = 8'd16,
    parameter logic [7:0]  DINO_H      = 8'd20,
    parameter logic [7:0]  SCREEN_BASE = 8'd220,
    parameter logic [7:0]  INIT_Y      = 8'd101,
    parameter logic [15:0] FG_COLOR    = 16'hFFFF,
    parameter logic [15:0] BG_COLOR    = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  dinoY,
    input  logic        dinoMovement,
    input  logic        redraw,
    input  logic        pix_ready,
    output logic        pix_valid,
    output logic [8:0]  pix_x,
    output logic [7:0]  pix_y,
    output logic [15:0] pix_color,
    output logic        drawDoneDino,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ERASE,
        S_DRAW,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [7:0]  r_new_y;
    logic [7:0]  r_old_y;
    logic [7:0]  r_last_y;
    logic [7:0]  r_row;
    logic [7:0]  r_col;

    logic        w_trigger;
    logic        w_fire;
    logic        w_last_col;
    logic        w_last_beat;
    logic [7:0]  w_base_y;

    assign w_trigger   = dinoMovement | redraw;
    assign w_fire      = pix_valid & pix_ready;
    assign w_last_col  = (r_col == DINO_W - 8'd1);
    assign w_last_beat = w_last_col && (r_row == DINO_H - 8'd1);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_trigger)
                    w_next = (r_last_y != dinoY) ? S_ERASE : S_DRAW;
            end
            S_ERASE: begin
                if (w_fire && w_last_beat) w_next = S_DRAW;
            end
            S_DRAW: begin
                if (w_fire && w_last_beat) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Inputs are only sampled in IDLE; the pass runs entirely on latched Y values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_new_y  <= 8'd0;
            r_old_y  <= 8'd0;
            r_last_y <= INIT_Y;
            r_row    <= 8'd0;
            r_col    <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        r_new_y <= dinoY;
                        r_old_y <= r_last_y;
                        r_row   <= 8'd0;
                        r_col   <= 8'd0;
                    end
                end
                S_ERASE, S_DRAW: begin
                    if (w_fire) begin
                        if (w_last_col) begin
                            r_col <= 8'd0;
                            r_row <= w_last_beat ? 8'd0 : r_row + 8'd1;
                        end else begin
                            r_col <= r_col + 8'd1;
                        end
                    end
                end
                S_DONE:  r_last_y <= r_new_y;
                default: ;
            endcase
        end
    end

    assign w_base_y     = (r_state == S_ERASE) ? r_old_y : r_new_y;
    assign pix_valid    = (r_state == S_ERASE) || (r_state == S_DRAW);
    assign busy         = (r_state != S_IDLE);
    assign drawDoneDino = (r_state == S_DONE);

    // Address/colour are driven to zero outside a pass so idle outputs are quiet.
    always_comb begin
        pix_x     = 9'd0;
        pix_y     = 8'd0;
        pix_color = 16'd0;
        if (pix_valid) begin
            pix_x     = DINO_X + {1'b0, r_col};
            pix_y     = SCREEN_BASE - w_base_y + r_row;
            pix_color = (r_state == S_ERASE) ? BG_COLOR : FG_COLOR;
        end
    end

endmodule

// File: tb/tb_dino_sprite_draw.sv
// Bench for dino_sprite_draw: a queue of expected beats per pass, checked every
// cycle, plus hand-computed latency/address literals per directed case.
module tb_dino_sprite_draw;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  dinoY = 8'd101;
    logic        dinoMovement = 1'b0;
    logic        redraw = 1'b0;
    logic        pix_ready = 1'b1;
    logic        pix_valid;
    logic [8:0]  pix_x;
    logic [7:0]  pix_y;
    logic [15:0] pix_color;
    logic        drawDoneDino;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    int acc   = 0;
    int dn    = 0;

    dino_sprite_draw dut (
        .clk(clk), .rst(rst), .dinoY(dinoY), .dinoMovement(dinoMovement),
        .redraw(redraw), .pix_ready(pix_ready), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .drawDoneDino(drawDoneDino), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Model: a pass is just a list of beats {x,y,colour}; a done cycle follows the last pop.
    logic [32:0] q[$];
    bit          m_on   = 1'b0;
    bit          m_idle = 1'b1;
    bit          m_done = 1'b0;
    logic [7:0]  m_last = 8'd101;
    logic [7:0]  m_new  = 8'd0;

    function automatic void push_rect(input logic [7:0] y, input logic [15:0] c);
        for (int r = 0; r < 20; r++)
            for (int cc = 0; cc < 16; cc++) begin
                logic [8:0] bx;
                logic [7:0] by;
                bx = 9'(20 + cc);
                by = 8'(220 - int'(y) + r);
                q.push_back({bx, by, c});
            end
    endfunction

    always @(posedge clk) begin
        cyc_n++;
        if (rst) begin
            q.delete();
            m_idle = 1'b1;
            m_done = 1'b0;
            m_last = 8'd101;
            m_on   = 1'b1;
        end else if (m_on) begin
            if (m_done) begin
                m_done = 1'b0;
                m_idle = 1'b1;
                m_last = m_new;
            end else if (m_idle) begin
                if (dinoMovement || redraw) begin
                    m_new = dinoY;
                    if (m_last != dinoY) push_rect(m_last, 16'h0000);
                    push_rect(dinoY, 16'hFFFF);
                    m_idle = 1'b0;
                end
            end else begin
                if (pix_ready) void'(q.pop_front());
                if (q.size() == 0) m_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            bit ev;
            ev = !m_idle && !m_done;
            chk("busy", busy, !m_idle);
            chk("done", drawDoneDino, m_done);
            chk("valid", pix_valid, ev);
            if (ev && q.size() > 0) begin
                chk("pix_x", pix_x, q[0][32:24]);
                chk("pix_y", pix_y, q[0][23:16]);
                chk("color", pix_color, q[0][15:0]);
            end
            if (pix_valid && pix_ready) acc++;
            if (drawDoneDino) dn++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs until drawDoneDino is seen; dcyc is the cycle label holding the pulse.
    task automatic wait_done(input int max, input bit bp, input int chg_at, output int dcyc);
        int k;
        k = 0;
        dcyc = -1;
        for (int i = 0; i < max; i++) begin
            tick();
            if (drawDoneDino) begin
                dcyc = cyc_n + 1;
                break;
            end
            if (chg_at >= 0 && acc >= chg_at) dinoY = 8'd121;
            if (bp) begin
                pix_ready = (k % 4 == 0) || (k % 4 == 3);
                k++;
            end
        end
        pix_ready = 1'b1;
        if (dcyc < 0) begin
            total++;
            bad++;
            $display("FAIL timeout waiting for drawDoneDino");
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int t, d1, d2, a0, n0;
        do_reset();
        chk("rst_valid", pix_valid, 1'b0);
        chk("rst_x", pix_x, 9'd0);
        chk("rst_y", pix_y, 8'd0);
        chk("rst_color", pix_color, 16'd0);
        chk("rst_busy", busy, 1'b0);

        // Case 1: quiet
        n0 = dn;
        repeat (50) tick();
        chk("quiet_done_cnt", dn - n0, 0);

        // Case 2: jump step 101 -> 112
        a0 = acc; n0 = dn;
        dinoY = 8'd112; dinoMovement = 1'b1;
        t = cyc_n + 1;
        tick();
        chk("c2_first_valid", pix_valid, 1'b1);
        chk("c2_first_x", pix_x, 9'd20);
        chk("c2_first_y", pix_y, 8'd119);
        chk("c2_first_color", pix_color, 16'h0000);
        wait_done(700, 1'b0, -1, d1);
        dinoMovement = 1'b0;
        chk("c2_latency", d1 - t, 641);
        tick();
        chk("c2_beats", acc - a0, 640);
        chk("c2_done_cnt", dn - n0, 1);

        // Case 3: forced redraw at unchanged Y
        do_reset();
        a0 = acc; n0 = dn;
        dinoY = 8'd101; redraw = 1'b1;
        t = cyc_n + 1;
        tick();
        redraw = 1'b0;
        chk("c3_first_y", pix_y, 8'd119);
        chk("c3_first_color", pix_color, 16'hFFFF);
        wait_done(400, 1'b0, -1, d1);
        chk("c3_latency", d1 - t, 321);
        tick();
        chk("c3_beats", acc - a0, 320);
        chk("c3_done_cnt", dn - n0, 1);

        // Case 4: backpressure 1,0,0,1
        a0 = acc; n0 = dn;
        dinoY = 8'd112; dinoMovement = 1'b1;
        tick();
        wait_done(2000, 1'b1, -1, d1);
        dinoMovement = 1'b0;
        tick();
        chk("c4_beats", acc - a0, 640);
        chk("c4_done_cnt", dn - n0, 1);

        // Case 5: draw-only pass at 112, Y moves to 121 mid-pass, movement held
        a0 = acc; n0 = dn;
        dinoY = 8'd112; dinoMovement = 1'b1;
        tick();
        wait_done(400, 1'b0, a0 + 100, d1);
        wait_done(700, 1'b0, -1, d2);
        dinoMovement = 1'b0;
        chk("c5_gap", d2 - d1, 642);
        tick();
        chk("c5_beats", acc - a0, 960);
        chk("c5_done_cnt", dn - n0, 2);

        // Case 6: reset during ERASE
        do_reset();
        n0 = dn; a0 = acc;
        dinoY = 8'd112; dinoMovement = 1'b1;
        for (int i = 0; i < 400 && (acc - a0) < 199; i++) tick();
        rst = 1'b1; dinoMovement = 1'b0;
        tick();
        rst = 1'b0;
        chk("c6_valid", pix_valid, 1'b0);
        chk("c6_busy", busy, 1'b0);
        repeat (3) tick();
        chk("c6_no_done", dn - n0, 0);
        dinoMovement = 1'b1;
        tick();
        chk("c6_restart_y", pix_y, 8'd119);
        chk("c6_restart_color", pix_color, 16'h0000);
        wait_done(700, 1'b0, -1, d1);
        dinoMovement = 1'b0;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
